// File: rtl/frame_packer.sv
// frame_packer: packs channel-tagged 16-bit words into 140-bit frames and strobes them into a downstream FIFO
module frame_packer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic [15:0]  data_in,
  input  logic [3:0]   data_in_ch,
  input  logic         data_in_last,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  input  logic         fifo_full,
  output logic         fifo_w_enable,
  output logic [139:0] data_to_fifo,
  output logic [15:0]  frame_count
);
  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
  state_t state;
  logic [3:0] ch, cnt, seq;
  logic [127:0] payload;
  logic [7:0] idle;
  logic [15:0] frames;
  logic mismatch, accept, timeout_hit;
  assign mismatch = data_in_valid && data_in_ch != ch;
  assign data_in_ready = !rst && (state == IDLE || (state == FILL && !mismatch));
  assign accept = data_in_valid && data_in_ready;
  assign fifo_w_enable = !rst && state == EMIT && !fifo_full;
  assign timeout_hit = TIMEOUT_CYCLES != 0 && {1'b0, idle} + 9'd1 == 9'(TIMEOUT_CYCLES);
  assign data_to_fifo = rst ? '0 : {ch, cnt, seq, payload};
  assign frame_count = rst ? '0 : frames;
  always_ff @(posedge clk_in)
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      cnt <= '0;
      seq <= '0;
      payload <= '0;
      idle <= '0;
      frames <= '0;
    end else
      case (state)
        IDLE: if (accept) begin
          ch <= data_in_ch;
          payload <= {data_in, 112'd0};
          cnt <= 4'd1;
          idle <= '0;
          state <= data_in_last ? EMIT : FILL;
        end
        FILL: if (accept) begin
          payload <= payload | ({data_in, 112'd0} >> {cnt, 4'd0});
          cnt <= cnt + 4'd1;
          idle <= '0;
          if (cnt == 4'd7 || data_in_last) state <= EMIT;
        end else begin
          idle <= idle + 8'd1;
          if (mismatch || timeout_hit) state <= EMIT;
        end
        EMIT: if (!fifo_full) begin
          state <= IDLE;
          seq <= seq + 4'd1;
          frames <= frames + 16'd1;
          payload <= '0;
          cnt <= '0;
          idle <= '0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer: table, directed and randomized checks of frame_packer against a frame-level model
module tb_frame_packer;
  logic clk_in = 0, rst = 1;
  logic [15:0] data_in = '0;
  logic [3:0] data_in_ch = '0;
  logic data_in_last = 0, data_in_valid = 0, fifo_full = 0;
  logic ready, wen, ready0, wen0;
  logic [139:0] dout, dout0;
  logic [15:0] fc, fc0;
  int vec = 0, miss = 0;
  logic mon_en = 0;
  logic [15:0] strobes;
  logic [139:0] exp_q[$];
  typedef struct {
    logic v;
    logic [3:0] ch;
    logic [15:0] d;
    logic last, full, e_rdy, e_wen, chk_d;
    logic [139:0] e_d;
  } vec_t;
  vec_t tbl[14];
  always #5 clk_in = ~clk_in;
  frame_packer #(.TIMEOUT_CYCLES(16)) dut (
    .clk_in(clk_in), .rst(rst), .data_in(data_in), .data_in_ch(data_in_ch),
    .data_in_last(data_in_last), .data_in_valid(data_in_valid), .data_in_ready(ready),
    .fifo_full(fifo_full), .fifo_w_enable(wen), .data_to_fifo(dout), .frame_count(fc)
  );
  frame_packer #(.TIMEOUT_CYCLES(0)) dut0 (
    .clk_in(clk_in), .rst(rst), .data_in(data_in), .data_in_ch(data_in_ch),
    .data_in_last(data_in_last), .data_in_valid(data_in_valid), .data_in_ready(ready0),
    .fifo_full(fifo_full), .fifo_w_enable(wen0), .data_to_fifo(dout0), .frame_count(fc0)
  );
  function automatic vec_t row(input logic v, input logic [3:0] ch, input logic [15:0] d,
                               input logic last, input logic full, input logic e_rdy,
                               input logic e_wen, input logic chk_d, input logic [139:0] e_d);
    vec_t r;
    r.v = v; r.ch = ch; r.d = d; r.last = last; r.full = full;
    r.e_rdy = e_rdy; r.e_wen = e_wen; r.chk_d = chk_d; r.e_d = e_d;
    return r;
  endfunction
  function automatic logic [139:0] mk(input logic [3:0] ch, input logic [3:0] seq,
                                      input logic [15:0] w[8], input int n);
    logic [127:0] p;
    p = '0;
    for (int k = 0; k < n; k++) p[127-16*k -: 16] = w[k];
    return {ch, 4'(n), seq, p};
  endfunction
  task automatic chk_b(input string nm, input logic act, input logic exp);
    vec++;
    if (act !== exp) begin miss++; $display("FAIL %s: got %b, expected %b", nm, act, exp); end
  endtask
  task automatic chk_c(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vec++;
    if (act !== exp) begin miss++; $display("FAIL %s: got %0d, expected %0d", nm, act, exp); end
  endtask
  task automatic chk_f(input string nm, input logic [139:0] act, input logic [139:0] exp);
    vec++;
    if (act !== exp) begin miss++; $display("FAIL %s: got %h, expected %h", nm, act, exp); end
  endtask
  task automatic drv(input logic v, input logic [3:0] ch, input logic [15:0] d, input logic l, input logic f);
    data_in_valid = v; data_in_ch = ch; data_in = d; data_in_last = l; fifo_full = f;
  endtask
  task automatic step(input logic v, input logic [3:0] ch, input logic [15:0] d, input logic l, input logic f);
    @(negedge clk_in);
    drv(v, ch, d, l, f);
    #1;
  endtask
  task automatic do_reset;
    @(negedge clk_in);
    rst = 1;
    drv(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    rst = 0;
  endtask
  always @(negedge clk_in) begin
    #2;
    if (mon_en && wen) begin
      if (exp_q.size() == 0) begin
        vec++; miss++;
        $display("FAIL rnd_unexpected: got frame %h, expected no write", dout);
      end else begin
        chk_f("rnd_frame", dout, exp_q.pop_front());
        chk_c("rnd_fc", fc, strobes);
      end
      chk_b("rnd_full_at_wen", fifo_full, 1'b0);
      strobes = strobes + 16'd1;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    logic any;
    logic [139:0] bp_exp;
    logic [15:0] words[8];
    int n, pushed, waited;
    logic [3:0] och, nch;
    logic [15:0] nd;
    logic nl, abort;
    drv(1'b1, 4'h9, 16'hffff, 1'b0, 1'b0);
    @(negedge clk_in);
    #1;
    chk_b("rst_ready", ready, 1'b0);
    chk_b("rst_wen", wen, 1'b0);
    chk_f("rst_data", dout, '0);
    chk_c("rst_fc", fc, 16'd0);
    do_reset;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 4'd3, 16'(i), 1'b0, 1'b0);
      chk_b("full_rdy", ready, 1'b1);
      chk_b("full_nowen", wen, 1'b0);
    end
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    chk_b("full_wen", wen, 1'b1);
    chk_f("full_data", dout, {4'h3, 4'h8, 4'h0, 128'h0001_0002_0003_0004_0005_0006_0007_0008});
    chk_c("full_fc_before", fc, 16'd0);
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    chk_b("full_single", wen, 1'b0);
    chk_c("full_fc", fc, 16'd1);
    for (int i = 1; i <= 8; i++) step(1'b1, 4'd6, 16'(16 + i), i == 8, 1'b0);
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    chk_b("last8_wen", wen, 1'b1);
    chk_f("last8_data", dout, {4'h6, 4'h8, 4'h1, 128'h0011_0012_0013_0014_0015_0016_0017_0018});
    any = 0;
    repeat (3) begin step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0); any |= wen; end
    chk_b("last8_one_frame", any, 1'b0);
    do_reset;
    step(1'b1, 4'd5, 16'h00a1, 1'b0, 1'b0);
    step(1'b1, 4'd5, 16'h00b2, 1'b0, 1'b0);
    step(1'b1, 4'd5, 16'h00c3, 1'b1, 1'b0);
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    chk_b("short_wen", wen, 1'b1);
    chk_f("short_data", dout, {4'h5, 4'h3, 4'h0, 16'h00a1, 16'h00b2, 16'h00c3, 80'h0});
    step(1'b1, 4'd5, 16'h0077, 1'b1, 1'b0);
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    chk_b("short2_wen", wen, 1'b1);
    chk_f("short2_seq1", dout, {4'h5, 4'h1, 4'h1, 16'h0077, 112'h0});
    step(1'b1, 4'd8, 16'h1234, 1'b0, 1'b1);
    step(1'b1, 4'd8, 16'h5678, 1'b1, 1'b1);
    bp_exp = {4'h8, 4'h2, 4'h2, 16'h1234, 16'h5678, 96'h0};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'd8, 16'h9999, 1'b0, 1'b1);
      chk_b("bp_nowen", wen, 1'b0);
      chk_b("bp_noready", ready, 1'b0);
      chk_f("bp_stable", dout, bp_exp);
    end
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    chk_b("bp_wen", wen, 1'b1);
    chk_f("bp_data", dout, bp_exp);
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    chk_b("bp_single", wen, 1'b0);
    chk_c("bp_fc", fc, 16'd3);
    do_reset;
    step(1'b1, 4'd6, 16'habcd, 1'b0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
      chk_b("to16_wen", wen, k == 17);
      if (k == 17) chk_f("to16_data", dout, {4'h6, 4'h1, 4'h0, 16'habcd, 112'h0});
    end
    any = 0;
    repeat (40) begin step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0); any |= wen0; end
    chk_b("to0_nowrite", any, 1'b0);
    do_reset;
    for (int i = 1; i <= 5; i++) step(1'b1, 4'd1, 16'(i), 1'b0, 1'b0);
    @(negedge clk_in);
    rst = 1;
    drv(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    #1;
    chk_b("rstmid_wen", wen, 1'b0);
    chk_b("rstmid_ready", ready, 1'b0);
    chk_f("rstmid_data", dout, '0);
    @(negedge clk_in);
    rst = 0;
    any = 0;
    repeat (20) begin step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0); any |= wen; end
    chk_b("rstmid_nowrite", any, 1'b0);
    chk_c("rstmid_fc", fc, 16'd0);
    step(1'b1, 4'd2, 16'h0055, 1'b1, 1'b0);
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    chk_b("rstmid_next_wen", wen, 1'b1);
    chk_f("rstmid_next_data", dout, {4'h2, 4'h1, 4'h0, 16'h0055, 112'h0});
    step(1'b1, 4'd3, 16'h0001, 1'b1, 1'b0);
    @(negedge clk_in);
    rst = 1;
    drv(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    #1;
    chk_b("rstemit_wen", wen, 1'b0);
    @(negedge clk_in);
    rst = 0;
    #1;
    chk_b("rstemit_after", wen, 1'b0);
    chk_c("rstemit_fc", fc, 16'd0);
    tbl[0]  = row(1'b1, 4'd3, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    tbl[1]  = row(1'b1, 4'd3, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    tbl[2]  = row(1'b1, 4'd4, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tbl[3]  = row(1'b1, 4'd4, 16'h0009, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    tbl[4]  = row(1'b1, 4'd4, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {4'h3, 4'h2, 4'h0, 16'h0001, 16'h0002, 96'h0});
    tbl[5]  = row(1'b1, 4'd4, 16'h0009, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    tbl[6]  = row(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {4'h4, 4'h1, 4'h1, 16'h0009, 112'h0});
    tbl[7]  = row(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    tbl[8]  = row(1'b1, 4'd2, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    tbl[9]  = row(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    tbl[10] = row(1'b1, 4'd7, 16'h00ee, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    tbl[11] = row(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    tbl[12] = row(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {4'h2, 4'h1, 4'h2, 16'h0005, 112'h0});
    tbl[13] = row(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    do_reset;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].last, tbl[i].full);
      chk_b($sformatf("tbl%0d_ready", i), ready, tbl[i].e_rdy);
      chk_b($sformatf("tbl%0d_wen", i), wen, tbl[i].e_wen);
      if (tbl[i].chk_d) chk_f($sformatf("tbl%0d_data", i), dout, tbl[i].e_d);
    end
    chk_c("tbl_fc", fc, 16'd3);
    do_reset;
    exp_q.delete();
    strobes = '0;
    n = 0;
    pushed = 0;
    och = '0;
    nch = '0;
    abort = 0;
    for (int i = 0; i < 8; i++) words[i] = '0;
    mon_en = 1;
    for (int w = 0; w < 300 && !abort; w++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk_in);
        data_in_valid = 0;
        fifo_full = $urandom_range(0, 3) == 0;
      end
      nch = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 3)) : nch;
      nd = 16'($urandom);
      nl = $urandom_range(0, 4) == 0;
      @(negedge clk_in);
      drv(1'b1, nch, nd, nl, $urandom_range(0, 3) == 0);
      if (n > 0 && nch != och) begin
        exp_q.push_back(mk(och, 4'(pushed), words, n));
        pushed++;
        n = 0;
      end
      #1;
      waited = 0;
      while (!ready && !abort) begin
        if (waited > 100) begin
          vec++; miss++;
          $display("FAIL rnd_accept: got no acceptance in 100 cycles, expected ready");
          abort = 1;
        end else begin
          @(negedge clk_in);
          fifo_full = $urandom_range(0, 3) == 0;
          #1;
          waited++;
        end
      end
      if (!abort) begin
        if (n == 0) och = nch;
        words[n] = nd;
        n++;
        if (nl || n == 8) begin
          exp_q.push_back(mk(och, 4'(pushed), words, n));
          pushed++;
          n = 0;
        end
      end
    end
    @(negedge clk_in);
    drv(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    if (n > 0) exp_q.push_back(mk(och, 4'(pushed), words, n));
    repeat (40) @(negedge clk_in);
    #3;
    chk_c("rnd_drain", 16'(exp_q.size()), 16'd0);
    chk_b("rnd_some_frames", strobes > 16'd20, 1'b1);
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
